// File: rtl/mesm6_alu_seq_if.sv
// Command/response handshake between the control unit and the ALU sequencer.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

interface mesm6_alu_seq_if;
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_load;
    logic [`ALU_OP_WIDTH-1:0] req_op;
    logic [47:0]              req_operand;
    logic                     rsp_valid;
    logic                     rsp_err;

    modport master (
        output req_valid, req_load, req_op, req_operand,
        input  req_ready, rsp_valid, rsp_err
    );

    modport slave (
        input  req_valid, req_load, req_op, req_operand,
        output req_ready, rsp_valid, rsp_err
    );
endinterface

// File: rtl/mesm6_alu_seq.sv
// Sequencer in front of mesm6_alu: owns A/Y, issues one op at a time and
// parks the ALU on NOP between ops so its unreset done/count state clears.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module mesm6_alu_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    mesm6_alu_seq_if.slave           bus,
    output logic [47:0]              acc,
    output logic [47:0]              y,
    output logic [47:0]              alu_a,
    output logic [47:0]              alu_b,
    output logic [`ALU_OP_WIDTH-1:0] alu_op,
    input  logic [47:0]              alu_result,
    input  logic [47:0]              alu_y,
    input  logic                     alu_done
);

    localparam logic [`ALU_OP_WIDTH-1:0] AluNop = '0;
    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StInit, StIdle, StExec, StRelease} state_e;

    state_e                   state_q, state_d;
    logic [47:0]              acc_q, acc_d;
    logic [47:0]              y_q, y_d;
    logic [47:0]              operand_q, operand_d;
    logic [`ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [TimerW-1:0]        timer_q, timer_d;
    logic                     err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StInit;
            acc_q     <= '0;
            y_q       <= '0;
            operand_q <= '0;
            op_q      <= AluNop;
            timer_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            operand_q <= operand_d;
            op_q      <= op_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        y_d       = y_q;
        operand_d = operand_q;
        op_d      = op_q;
        timer_d   = timer_q;
        err_d     = err_q;

        case (state_q)
            StInit: state_d = StIdle;
            StIdle: begin
                if (bus.req_valid) begin
                    operand_d = bus.req_operand;
                    op_d      = bus.req_op;
                    timer_d   = '0;
                    if (bus.req_load || bus.req_op == AluNop) begin
                        err_d   = 1'b0;
                        state_d = StRelease;
                        if (bus.req_load) begin
                            acc_d = bus.req_operand;
                        end
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                timer_d = timer_q + 1'b1;
                // First EXEC cycle may still see done left over from the previous op.
                if (alu_done && timer_q != '0) begin
                    acc_d   = alu_result;
                    y_d     = alu_y;
                    err_d   = 1'b0;
                    state_d = StRelease;
                end else if (timer_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StInit;
        endcase
    end

    always_comb begin
        alu_op = AluNop;
        if (reset_n && state_q == StExec) begin
            alu_op = op_q;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StRelease);
    assign bus.rsp_err   = err_q;
    assign acc           = acc_q;
    assign y             = y_q;
    assign alu_a         = acc_q;
    assign alu_b         = operand_q;

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// Directed bench for mesm6_alu_seq with a small behavioural ALU stub.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module tb_mesm6_alu_seq;

    localparam logic [4:0] OpNop  = 5'd0;
    localparam logic [4:0] OpAnd  = 5'd1;
    localparam logic [4:0] OpOr   = 5'd2;
    localparam logic [4:0] OpXor  = 5'd3;
    localparam logic [4:0] OpAdd  = 5'd7;
    localparam logic [4:0] OpCnt  = 5'd8;
    localparam logic [4:0] OpFadd = 5'd16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [47:0] acc, y, alu_a, alu_b, alu_result, alu_y;
    logic [4:0]  alu_op;
    logic        alu_done;
    logic        stale_done = 1'b1;

    mesm6_alu_seq_if bus ();

    mesm6_alu_seq #(.TIMEOUT_CYCLES(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .acc        (acc),
        .y          (y),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_y      (alu_y),
        .alu_done   (alu_done)
    );

    always #5 clk = ~clk;

    // ALU stub: done after 1 or 2 cycles of a held op, never for FP ops.
    logic [1:0] cnt = 2'd0;
    logic [1:0] need;
    logic [48:0] sum;
    always @(posedge clk) begin
        if (alu_op == OpNop) cnt <= 2'd0;
        else if (cnt != 2'd3) cnt <= cnt + 2'd1;
    end

    always_comb begin
        need       = 2'd0;
        alu_result = '0;
        alu_y      = '0;
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_op)
            OpAnd: begin need = 2'd1; alu_result = alu_a & alu_b; end
            OpOr:  begin need = 2'd1; alu_result = alu_a | alu_b; end
            OpXor: begin need = 2'd1; alu_result = alu_a ^ alu_b; alu_y = alu_a; end
            OpAdd: begin need = 2'd2; alu_result = sum[47:0] + {47'd0, sum[48]}; end
            OpCnt: begin need = 2'd2; alu_result = 48'($countones(alu_a)); end
            default: ;
        endcase
    end

    assign alu_done = stale_done | (need != 2'd0 && cnt >= need);

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("ready_wait", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(inout int lat);
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 40);
    endtask

    task automatic run_req(input logic ld, input logic [4:0] op, input logic [47:0] opnd,
                           output int lat);
        wait_ready();
        bus.req_valid   = 1'b1;
        bus.req_load    = ld;
        bus.req_op      = op;
        bus.req_operand = opnd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        wait_rsp(lat);
    endtask

    typedef struct {
        logic        ld;
        logic [4:0]  op;
        logic [47:0] opnd;
        logic [47:0] e_acc;
        logic [47:0] e_y;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat;
        vecs[0]  = '{1'b1, OpNop,  48'hFFFF,         48'hFFFF,         48'h0, 1'b0, 1};
        vecs[1]  = '{1'b0, OpAnd,  48'h00FF,         48'h00FF,         48'h0, 1'b0, 3};
        vecs[2]  = '{1'b1, OpNop,  48'h7,            48'h7,            48'h0, 1'b0, 1};
        vecs[3]  = '{1'b0, OpCnt,  48'h0,            48'h3,            48'h0, 1'b0, 4};
        vecs[4]  = '{1'b1, OpNop,  48'h5,            48'h5,            48'h0, 1'b0, 1};
        vecs[5]  = '{1'b0, OpXor,  48'h3,            48'h6,            48'h5, 1'b0, 3};
        vecs[6]  = '{1'b0, OpNop,  48'hABC,          48'h6,            48'h5, 1'b0, 1};
        vecs[7]  = '{1'b1, OpNop,  48'h1234,         48'h1234,         48'h5, 1'b0, 1};
        vecs[8]  = '{1'b0, OpFadd, 48'h1,            48'h1234,         48'h5, 1'b1, 16};
        vecs[9]  = '{1'b0, OpOr,   48'h0F00,         48'h1F34,         48'h0, 1'b0, 3};
        vecs[10] = '{1'b1, OpNop,  48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'h0, 1'b0, 1};
        vecs[11] = '{1'b0, OpAdd,  48'h1,            48'h1,            48'h0, 1'b0, 4};

        bus.req_valid   = 1'b0;
        bus.req_load    = 1'b0;
        bus.req_op      = OpNop;
        bus.req_operand = '0;

        // Reset with a stale done held through reset and INIT.
        repeat (3) @(negedge clk);
        chk("rst_acc", 64'(acc), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'(OpNop));
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("init_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("idle_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid   = 1'b1;
        bus.req_load    = 1'b0;
        bus.req_op      = OpAnd;
        bus.req_operand = 48'h0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("stale_exec1_rsp", 64'(bus.rsp_valid), 64'd0);
        stale_done = 1'b0;
        lat = 1;
        wait_rsp(lat);
        chk("stale_lat", 64'(lat), 64'd3);

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].ld, vecs[i].op, vecs[i].opnd, lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].e_lat));
            chk($sformatf("v%0d_acc", i), 64'(acc), 64'(vecs[i].e_acc));
            chk($sformatf("v%0d_y", i), 64'(y), 64'(vecs[i].e_y));
            chk($sformatf("v%0d_err", i), 64'(bus.rsp_err), 64'(vecs[i].e_err));
            chk($sformatf("v%0d_rel_op", i), 64'(alu_op), 64'(OpNop));
        end

        // Request held valid while busy, with inputs changing during EXEC.
        run_req(1'b1, OpNop, 48'hF0, lat);
        chk("hold_load_acc", 64'(acc), 64'hF0);
        wait_ready();
        bus.req_valid   = 1'b1;
        bus.req_load    = 1'b0;
        bus.req_op      = OpAnd;
        bus.req_operand = 48'h3C;
        @(posedge clk);
        #1;
        bus.req_op      = OpOr;
        bus.req_operand = 48'h01;
        lat = 0;
        wait_rsp(lat);
        chk("hold_first_lat", 64'(lat), 64'd3);
        chk("hold_first_acc", 64'(acc), 64'h30);
        chk("hold_rel_ready", 64'(bus.req_ready), 64'd0);
        lat = 0;
        wait_rsp(lat);
        bus.req_valid = 1'b0;
        chk("hold_second_gap", 64'(lat), 64'd4);
        chk("hold_second_acc", 64'(acc), 64'h31);

        // Reset in the second EXEC cycle of an add.
        wait_ready();
        bus.req_valid   = 1'b1;
        bus.req_op      = OpAdd;
        bus.req_operand = 48'h5;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_exec1_op", 64'(alu_op), 64'(OpAdd));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_alu_op", 64'(alu_op), 64'(OpNop));
        chk("midrst_acc", 64'(acc), 64'd0);
        chk("midrst_y", 64'(y), 64'd0);
        chk("midrst_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_ready", 64'(bus.req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_hold_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_init_ready", 64'(bus.req_ready), 64'd0);
        chk("midrst_init_rsp", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("midrst_idle_ready", 64'(bus.req_ready), 64'd1);
        run_req(1'b1, OpNop, 48'h9, lat);
        chk("post_rst_lat", 64'(lat), 64'd1);
        chk("post_rst_acc", 64'(acc), 64'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mesm6_alu_seq.md
Name: mesm6_alu_seq

Overview:
- Upstream sequencer for mesm6_alu. It owns the accumulator (A) and Y registers.
- Accepts one command at a time from the control unit over a valid/ready handshake.
- Drives the ALU op/operands and waits for done, then writes back result and y.
- Forces the ALU back to ALU_NOP, so the ALU's unreset done/count state is always cleared between operations.

Parameters:
- TIMEOUT_CYCLES, 15: max EXEC cycles spent waiting for alu_done before aborting with an error (covers unimplemented FP ops).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  sequencer can accept a command (IDLE only)
- req_load  in  1  1 = load req_operand into A, bypassing the ALU
- req_op  in  `ALU_OP_WIDTH  ALU operation for non-load commands
- req_operand  in  48  operand (B input of ALU, or load value)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid: timeout abort
- acc  out  48  accumulator register
- y  out  48  Y register
- alu_a  out  48  to ALU a (= acc)
- alu_b  out  48  to ALU b (latched operand)
- alu_op  out  `ALU_OP_WIDTH  to ALU op
- alu_result  in  48  from ALU result
- alu_y  in  48  from ALU y
- alu_done  in  1  from ALU done

Behaviour:
- Reset (async, reset_n=0):
  - state=INIT; acc=0, y=0, operand latch=0, timer=0.
  - rsp_valid=0, rsp_err=0, req_ready=0.
  - alu_op=ALU_NOP, forced combinationally while reset_n=0.
- States: INIT, IDLE, EXEC, RELEASE.
- INIT:
  - One cycle with alu_op=NOP, which clears a stale ALU done after power-up or reset.
  - Then -> IDLE.
- IDLE:
  - req_ready=1; alu_op=NOP.
  - On req_valid & req_ready:
    - Latch req_operand and req_op; clear the timer.
    - If req_load=1 or req_op=ALU_NOP, go to RELEASE. For a load, acc<=req_operand at the same edge; y is unchanged. ALU_NOP changes nothing.
    - Otherwise go to EXEC.
- EXEC:
  - alu_op=latched op, alu_a=acc, alu_b=latched operand.
  - acc is stable for the whole of EXEC.
  - alu_done is ignored in the first EXEC cycle (stale guard); the timer increments every EXEC cycle.
  - On alu_done=1 (cycle 2 or later): acc<=alu_result, y<=alu_y, rsp_err<=0, -> RELEASE.
  - Else if timer reaches TIMEOUT_CYCLES: acc and y unchanged, rsp_err<=1, -> RELEASE.
- RELEASE:
  - alu_op=NOP (ALU clears done/count at this edge).
  - rsp_valid=1 for exactly this cycle; acc and y already hold the new values.
  - -> IDLE.
- Outputs outside their states: req_ready=0 outside IDLE; rsp_valid=0 outside RELEASE; rsp_err holds until the next RELEASE.
- Latency, from the accept edge to the rsp_valid cycle:
  - load: 1 cycle
  - 1-cycle ALU ops (AND/OR/XOR/SHIFT/PACK/UNPACK): 3 cycles
  - 2-cycle ops (ADD_CARRY_AROUND/COUNT/CLZ): 4 cycles
  - timeout: TIMEOUT_CYCLES+1 cycles
- Throughput: a new request is accepted on the cycle after RELEASE at the earliest; no back-to-back overlap.
- req_valid asserted while busy is ignored (not latched). The requester must hold req_valid until req_ready.
- req_* inputs change during EXEC: no effect, because the operands are latched.
- Reset asserted mid-EXEC: alu_op drops to NOP immediately, registers clear, no rsp_valid.
  - After reset_n rises, the sequencer passes through INIT before accepting a request.
- Width rules: all datapath is 48-bit; no extension or truncation in this block.

Test Plan:
- After reset: req_ready=0 for INIT then 1. With a stale alu_done=1 held during INIT, the first op still waits a full cycle.
- Load acc=48'hFFFF, then AND with 48'h00FF -> rsp_valid 3 cycles after accept, acc=48'h00FF, y=0, rsp_err=0.
- acc=48'h7, COUNT with operand 0 -> rsp_valid 4 cycles after accept, acc=3, y=0.
- acc=48'h5, XOR with 48'h3 -> acc=48'h6, y=48'h5.
- FADD (no done ever) with acc=48'h1234 -> rsp_valid after TIMEOUT_CYCLES+1 cycles, rsp_err=1, acc=48'h1234, alu_op=NOP in the RELEASE cycle.
- reset_n pulsed low in the second EXEC cycle of ADD_CARRY_AROUND -> alu_op=NOP immediately, acc=0, no rsp_valid, INIT then IDLE. A second req_valid held during EXEC is accepted only after RELEASE.
